dtmf_row_detect: RTL

Measures the period of an incoming DTMF row-tone square wave, such as the output of the team's 697/770/852/941 Hz stepdown dividers or a comparator-sliced analog tone, against the 1 MHz system clock. Classifies each period into one of the four DTMF row frequencies. Asserts a qualified tone-valid with a 2-bit row code once the classification is stable. This is the receive-side counterpart of the tone generators, feeding the keypad decode logic and the Nios PIO.

---
 rtl/dtmf_row_detect.sv | 117 +++++++++++
 1 files changed

// File: rtl/dtmf_row_detect.sv
// dtmf_row_detect: classifies a DTMF row tone by period and locks after CONFIRM matching periods.
// `DTMF_ROW_DROP_FILTER_EN lets a locked tone ride through one stray period.
module dtmf_row_detect #(
  parameter int P697    = 1435,
  parameter int P770    = 1299,
  parameter int P852    = 1174,
  parameter int P941    = 1063,
  parameter int TOL     = 40,
  parameter int CONFIRM = 3,
  parameter int TIMEOUT = 2000
) (
  input  logic        clk_1m_in,
  input  logic        reset,
  input  logic        tone_in,
  output logic        tone_valid,
  output logic [1:0]  row_code,
  output logic        new_tone,
  output logic [11:0] period_out
);
`ifdef DTMF_ROW_DROP_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif
  localparam logic [11:0] TOL_W = 12'(TOL);
  localparam logic [11:0] TMO   = 12'(TIMEOUT);
  localparam logic [2:0]  CONF  = 3'(CONFIRM);
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
  state_t state, state_n;
  logic s1, s2, s3, rise, hit, tmo, miss, miss_n, valid_n, new_n;
  logic [11:0] cnt, per_n;
  logic [1:0] cls, cand, cand_n, code_n;
  logic [2:0] match_cnt, match_n;
  logic [3:0] win;
  function automatic logic in_win(input logic [11:0] p, input logic [11:0] c);
    return p >= c - TOL_W && p <= c + TOL_W;
  endfunction
  assign rise = s2 & ~s3;
  assign win  = {in_win(cnt, 12'(P941)), in_win(cnt, 12'(P852)), in_win(cnt, 12'(P770)), in_win(cnt, 12'(P697))};
  assign hit  = |win;
  assign cls  = win[3] ? 2'd3 : win[2] ? 2'd2 : win[1] ? 2'd1 : 2'd0;
  assign tmo  = cnt >= TMO;
  always_ff @(posedge clk_1m_in or posedge reset)
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      cnt        <= '0;
      state      <= IDLE;
      cand       <= '0;
      match_cnt  <= '0;
      miss       <= 1'b0;
      tone_valid <= 1'b0;
      row_code   <= '0;
      new_tone   <= 1'b0;
      period_out <= '0;
    end else begin
      s1         <= tone_in;
      s2         <= s1;
      s3         <= s2;
      cnt        <= rise ? 12'd1 : cnt + {11'd0, ~&cnt};
      state      <= state_n;
      cand       <= cand_n;
      match_cnt  <= match_n;
      miss       <= miss_n;
      tone_valid <= valid_n;
      row_code   <= code_n;
      new_tone   <= new_n;
      period_out <= per_n;
    end
  // A rise is always checked before the timeout so that a rise wins a same-cycle tie.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    match_n = match_cnt;
    miss_n  = miss;
    valid_n = tone_valid;
    code_n  = row_code;
    new_n   = 1'b0;
    per_n   = (rise && state != IDLE) ? cnt : period_out;
    case (state)
      IDLE: state_n = rise ? MEASURE : IDLE;
      MEASURE:
        if (rise) begin
          cand_n  = hit ? cls : cand;
          match_n = !hit ? 3'd0 : (cls == cand) ? match_cnt + 3'd1 : 3'd1;
          if (match_n >= CONF) begin
            state_n = LOCKED;
            valid_n = 1'b1;
            code_n  = cand_n;
            new_n   = 1'b1;
          end
        end else if (tmo) begin
          state_n = IDLE;
          match_n = 3'd0;
        end
      LOCKED:
        if (rise) begin
          if (hit && cls == row_code) miss_n = 1'b0;
          else if (FILTER && !miss) miss_n = 1'b1;
          else begin
            state_n = MEASURE;
            valid_n = 1'b0;
            miss_n  = 1'b0;
            cand_n  = hit ? cls : cand;
            match_n = {2'd0, hit};
          end
        end else if (tmo) begin
          state_n = IDLE;
          valid_n = 1'b0;
          match_n = 3'd0;
          miss_n  = 1'b0;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule
